// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-bank writeback arbiter.
//   XLEN        : writeback / register data width
//   REG_ADDR_W  : register index width (32 architectural registers)
//   prio_state_t: arbitration priority state (load-first or ALU-first)
//   wb_req_t    : one writeback request (valid, destination, data)
package regfile_wb_arbiter_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef enum logic [0:0] {
    PRIO_LD  = 1'b0,
    PRIO_ALU = 1'b1
  } prio_state_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_wb_scoreboard.sv
// wb_scoreboard: per-register busy bits for outstanding writes plus the
// decode hazard compare.
//   clk, rst          : clock, synchronous active-high reset (clears all bits)
//   dec_*_i           : instruction currently presented by decode
//   clr_en_i/idx_i    : writeback grant clearing busy[idx] at the next edge
//   dec_stall_o       : RAW/WAW hazard against registered busy bits
//   busy_vec_o        : bit i set while a write to xi is outstanding
module wb_scoreboard
  import regfile_wb_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dec_valid_i,
  input  logic [REG_ADDR_W-1:0] dec_rs1_i,
  input  logic [REG_ADDR_W-1:0] dec_rs2_i,
  input  logic [REG_ADDR_W-1:0] dec_rd_i,
  input  logic                  dec_wr_en_i,
  input  logic                  clr_en_i,
  input  logic [REG_ADDR_W-1:0] clr_idx_i,
  output logic                  dec_stall_o,
  output logic [NUM_REGS-1:0]   busy_vec_o
);
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [NUM_REGS-1:0] set_mask, clr_mask;
  logic                issue;

  // Stall compares against registered busy only: a grant clearing rd in this
  // cycle never lets a dependent instruction slip through the same cycle.
  assign dec_stall_o = dec_valid_i & (busy_q[dec_rs1_i] | busy_q[dec_rs2_i] |
                                      (dec_wr_en_i & busy_q[dec_rd_i]));
  assign issue = dec_valid_i & ~dec_stall_o & dec_wr_en_i & (dec_rd_i != '0);

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue)    set_mask[dec_rd_i]  = 1'b1;
    if (clr_en_i) clr_mask[clr_idx_i] = 1'b1;
    busy_d    = (busy_q & ~clr_mask) | set_mask;
    busy_d[0] = 1'b0;  // x0 is hardwired, never outstanding
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy_vec_o = busy_q;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: owns the register bank's single write port.
// Arbitrates ALU and load writebacks (load first, with an ALU starvation
// guard), registers the winning write, and tracks outstanding writes so
// decode stalls on RAW/WAW hazards.
//
// Handshake: a transfer happens on a cycle where valid & ready are both high
// at the rising edge. Requesters hold valid/rd/data stable until ready. Ready
// is combinational from the valids and the priority state; at most one ready
// is high per cycle, and both are low while rst is high.
//
// Ports: clk/rst; dec_* decode hazard query and dec_stall; alu_wb_* and
// ld_wb_* writeback requests with their readies; rf_we/rf_waddr/rf_wdata
// registered write port; busy_vec scoreboard; dbg_prio_state current
// priority state. err_spurious (sticky) exists only when
// WB_SPURIOUS_CHECK_EN is defined.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int XLEN         = regfile_wb_arbiter_pkg::XLEN,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dec_valid,
  input  logic [REG_ADDR_W-1:0] dec_rs1,
  input  logic [REG_ADDR_W-1:0] dec_rs2,
  input  logic [REG_ADDR_W-1:0] dec_rd,
  input  logic                  dec_wr_en,
  output logic                  dec_stall,
  input  logic                  alu_wb_valid,
  input  logic [REG_ADDR_W-1:0] alu_wb_rd,
  input  logic [XLEN-1:0]       alu_wb_data,
  output logic                  alu_wb_ready,
  input  logic                  ld_wb_valid,
  input  logic [REG_ADDR_W-1:0] ld_wb_rd,
  input  logic [XLEN-1:0]       ld_wb_data,
  output logic                  ld_wb_ready,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
`ifdef WB_SPURIOUS_CHECK_EN
  output logic                  err_spurious,
`endif
  output prio_state_t           dbg_prio_state,
  output logic [NUM_REGS-1:0]   busy_vec
);
  prio_state_t           prio_q, prio_d;
  logic [3:0]            starve_cnt_q, starve_cnt_d;
  logic                  alu_gnt, ld_gnt;
  wb_req_t               gnt;
  logic                  rf_we_q;
  logic [REG_ADDR_W-1:0] rf_waddr_q;
  logic [XLEN-1:0]       rf_wdata_q;

  always_comb begin
    alu_wb_ready = 1'b0;
    ld_wb_ready  = 1'b0;
    if (!rst) begin
      if (prio_q == PRIO_ALU) begin
        alu_wb_ready = alu_wb_valid;
        ld_wb_ready  = ld_wb_valid & ~alu_wb_valid;
      end else begin
        ld_wb_ready  = ld_wb_valid;
        alu_wb_ready = alu_wb_valid & ~ld_wb_valid;
      end
    end
  end

  assign alu_gnt = alu_wb_valid & alu_wb_ready;
  assign ld_gnt  = ld_wb_valid & ld_wb_ready;

  always_comb begin
    gnt.valid = alu_gnt | ld_gnt;
    gnt.rd    = ld_gnt ? ld_wb_rd   : alu_wb_rd;
    gnt.data  = ld_gnt ? ld_wb_data : alu_wb_data;
  end

  // Starvation counter counts cycles the ALU waited while the load won.
  // PRIO_ALU lasts only until the ALU is served or stops asking.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    prio_d       = prio_q;
    if (alu_gnt || !alu_wb_valid) starve_cnt_d = '0;
    else if (ld_gnt)              starve_cnt_d = starve_cnt_q + 4'd1;
    case (prio_q)
      PRIO_LD:  if (starve_cnt_d == 4'(STARVE_LIMIT)) prio_d = PRIO_ALU;
      PRIO_ALU: if (alu_gnt || !alu_wb_valid)         prio_d = PRIO_LD;
      default:  prio_d = PRIO_LD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q       <= PRIO_LD;
      starve_cnt_q <= '0;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
    end else begin
      prio_q       <= prio_d;
      starve_cnt_q <= starve_cnt_d;
      // A grant to x0 completes the handshake but never writes the bank.
      rf_we_q      <= gnt.valid & (gnt.rd != '0);
      if (gnt.valid && gnt.rd != '0) begin
        rf_waddr_q <= gnt.rd;
        rf_wdata_q <= gnt.data;
      end
    end
  end

  assign rf_we          = rf_we_q;
  assign rf_waddr       = rf_waddr_q;
  assign rf_wdata       = rf_wdata_q;
  assign dbg_prio_state = prio_q;

  wb_scoreboard u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .dec_valid_i (dec_valid),
    .dec_rs1_i   (dec_rs1),
    .dec_rs2_i   (dec_rs2),
    .dec_rd_i    (dec_rd),
    .dec_wr_en_i (dec_wr_en),
    .clr_en_i    (gnt.valid),
    .clr_idx_i   (gnt.rd),
    .dec_stall_o (dec_stall),
    .busy_vec_o  (busy_vec)
  );

`ifdef WB_SPURIOUS_CHECK_EN
  // Flags a writeback to a register nobody issued a write for.
  logic err_spurious_q;
  always_ff @(posedge clk) begin
    if (rst) err_spurious_q <= 1'b0;
    else if (gnt.valid && gnt.rd != '0 && !busy_vec[gnt.rd]) err_spurious_q <= 1'b1;
  end
  assign err_spurious = err_spurious_q;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, single writes, hazard stall
// table, starvation sequence table, x0 writes, reset mid-operation.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              dec_valid, dec_wr_en, dec_stall;
  logic [4:0]        dec_rs1, dec_rs2, dec_rd;
  logic              alu_wb_valid, alu_wb_ready, ld_wb_valid, ld_wb_ready;
  logic [4:0]        alu_wb_rd, ld_wb_rd, rf_waddr;
  logic [31:0]       alu_wb_data, ld_wb_data, rf_wdata, busy_vec;
  logic              rf_we;
  prio_state_t       dbg_prio_state;
`ifdef WB_SPURIOUS_CHECK_EN
  logic              err_spurious;
`endif

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(.XLEN(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rd(dec_rd), .dec_wr_en(dec_wr_en), .dec_stall(dec_stall),
    .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd),
    .alu_wb_data(alu_wb_data), .alu_wb_ready(alu_wb_ready),
    .ld_wb_valid(ld_wb_valid), .ld_wb_rd(ld_wb_rd),
    .ld_wb_data(ld_wb_data), .ld_wb_ready(ld_wb_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
`ifdef WB_SPURIOUS_CHECK_EN
    .err_spurious(err_spurious),
`endif
    .dbg_prio_state(dbg_prio_state), .busy_vec(busy_vec)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       v;
    logic [4:0] rs1, rs2, rd;
    logic       we;
    logic       exp_stall;
  } stall_vec_t;

  typedef struct {
    logic        alu_v, ld_v;
    logic        exp_alu_rdy, exp_ld_rdy;
    prio_state_t exp_state;
    logic [4:0]  exp_waddr;
  } arb_vec_t;

  stall_vec_t sv[7];
  arb_vec_t   av[14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [4:0] rd);
    dec_valid = 1'b1; dec_wr_en = 1'b1; dec_rd = rd; dec_rs1 = '0; dec_rs2 = '0;
    tick();
    dec_valid = 1'b0; dec_wr_en = 1'b0;
  endtask

  initial begin
    // busy_vec = {x7} during this table
    sv[0] = '{1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b1};
    sv[1] = '{1'b1, 5'd3, 5'd4, 5'd7, 1'b1, 1'b1};
    sv[2] = '{1'b1, 5'd3, 5'd4, 5'd8, 1'b1, 1'b0};
    sv[3] = '{1'b1, 5'd0, 5'd7, 5'd8, 1'b1, 1'b1};
    sv[4] = '{1'b1, 5'd3, 5'd4, 5'd7, 1'b0, 1'b0};
    sv[5] = '{1'b0, 5'd7, 5'd7, 5'd7, 1'b1, 1'b0};
    sv[6] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0};
    // ALU rd=10, load rd=11; starting from PRIO_LD with counter 0
    av[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, PRIO_LD,  5'd11};
    av[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, PRIO_LD,  5'd11};
    av[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, PRIO_LD,  5'd11};
    av[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, PRIO_LD,  5'd11};
    av[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, PRIO_ALU, 5'd10};
    av[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, PRIO_LD,  5'd11};
    av[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, PRIO_LD,  5'd11};
    av[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, PRIO_LD,  5'd11};
    av[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, PRIO_LD,  5'd11};
    av[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, PRIO_LD,  5'd11};
    av[10] = '{1'b1, 1'b1, 1'b0, 1'b1, PRIO_LD,  5'd11};
    av[11] = '{1'b0, 1'b1, 1'b0, 1'b1, PRIO_ALU, 5'd11};
    av[12] = '{1'b1, 1'b0, 1'b1, 1'b0, PRIO_LD,  5'd10};
    av[13] = '{1'b1, 1'b1, 1'b0, 1'b1, PRIO_LD,  5'd11};

    // reset with both requesters active
    rst = 1'b1;
    dec_valid = 1'b0; dec_wr_en = 1'b0; dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;
    alu_wb_valid = 1'b1; alu_wb_rd = '0; alu_wb_data = 32'h1111_1111;
    ld_wb_valid  = 1'b1; ld_wb_rd  = '0; ld_wb_data  = 32'h2222_2222;
    #1;
    chk("rst_alu_ready_pre", alu_wb_ready, 1'b0);
    chk("rst_ld_ready_pre", ld_wb_ready, 1'b0);
    tick(); tick();
    chk("rst_alu_ready", alu_wb_ready, 1'b0);
    chk("rst_ld_ready", ld_wb_ready, 1'b0);
    chk("rst_rf_we", rf_we, 1'b0);
    chk("rst_waddr", rf_waddr, 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    chk("rst_busy", busy_vec, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ld_ready", ld_wb_ready, 1'b1);
    chk("post_rst_alu_ready", alu_wb_ready, 1'b0);
    tick();  // load to x0 granted here
    alu_wb_valid = 1'b0; ld_wb_valid = 1'b0;
    chk("x0_rf_we", rf_we, 1'b0);
    chk("x0_busy", busy_vec, 32'd0);

    // single ALU write to x5
    dec_valid = 1'b1; dec_wr_en = 1'b1; dec_rd = 5'd5;
    #1 chk("issue5_stall", dec_stall, 1'b0);
    tick();
    dec_valid = 1'b0; dec_wr_en = 1'b0;
    chk("issue5_busy", busy_vec, 32'h0000_0020);
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd5; alu_wb_data = 32'hDEAD_BEEF;
    #1;
    chk("alu5_ready", alu_wb_ready, 1'b1);
    chk("alu5_ld_ready", ld_wb_ready, 1'b0);
    tick();
    alu_wb_valid = 1'b0;
    chk("alu5_rf_we", rf_we, 1'b1);
    chk("alu5_waddr", rf_waddr, 32'd5);
    chk("alu5_wdata", rf_wdata, 32'hDEAD_BEEF);
    chk("alu5_busy_clr", busy_vec, 32'd0);
    tick();
    chk("idle_rf_we", rf_we, 1'b0);
    chk("idle_waddr_hold", rf_waddr, 32'd5);
    chk("idle_wdata_hold", rf_wdata, 32'hDEAD_BEEF);

    // hazard table with x7 busy
    issue(5'd7);
    chk("issue7_busy", busy_vec, 32'h0000_0080);
    for (int i = 0; i < 7; i++) begin
      dec_valid = sv[i].v; dec_rs1 = sv[i].rs1; dec_rs2 = sv[i].rs2;
      dec_rd = sv[i].rd; dec_wr_en = sv[i].we;
      #1 chk($sformatf("stall_vec%0d", i), dec_stall, sv[i].exp_stall);
      dec_valid = 1'b0; dec_wr_en = 1'b0;
    end
    issue(5'd0);
    chk("issue_x0_busy", busy_vec, 32'h0000_0080);

    // load clears x7
    ld_wb_valid = 1'b1; ld_wb_rd = 5'd7; ld_wb_data = 32'h1234_5678;
    #1 chk("ld7_ready", ld_wb_ready, 1'b1);
    tick();
    ld_wb_valid = 1'b0;
    chk("ld7_rf_we", rf_we, 1'b1);
    chk("ld7_waddr", rf_waddr, 32'd7);
    chk("ld7_wdata", rf_wdata, 32'h1234_5678);
    chk("ld7_busy", busy_vec, 32'd0);
    tick();

    // starvation table: one grant every cycle
    alu_wb_rd = 5'd10; alu_wb_data = 32'hAAAA_0010;
    ld_wb_rd  = 5'd11; ld_wb_data  = 32'hBBBB_0011;
    for (int i = 0; i < 14; i++) begin
      alu_wb_valid = av[i].alu_v; ld_wb_valid = av[i].ld_v;
      #1;
      chk($sformatf("arb%0d_alu_ready", i), alu_wb_ready, av[i].exp_alu_rdy);
      chk($sformatf("arb%0d_ld_ready", i), ld_wb_ready, av[i].exp_ld_rdy);
      chk($sformatf("arb%0d_state", i), dbg_prio_state, av[i].exp_state);
      tick();
      chk($sformatf("arb%0d_rf_we", i), rf_we, 1'b1);
      chk($sformatf("arb%0d_waddr", i), rf_waddr, av[i].exp_waddr);
    end
    alu_wb_valid = 1'b0; ld_wb_valid = 1'b0;
    tick();
    chk("arb_busy_untouched", busy_vec, 32'd0);

    // reset in the middle of a pending write
    issue(5'd12);
    chk("issue12_busy", busy_vec, 32'h0000_1000);
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd12; alu_wb_data = 32'hCAFE_0012;
    rst = 1'b1;
    #1 chk("midrst_alu_ready", alu_wb_ready, 1'b0);
    tick();
    rst = 1'b0; alu_wb_valid = 1'b0;
    chk("midrst_rf_we", rf_we, 1'b0);
    chk("midrst_busy", busy_vec, 32'd0);
    chk("midrst_waddr", rf_waddr, 32'd0);
    tick();

`ifdef WB_SPURIOUS_CHECK_EN
    chk("spur_init", err_spurious, 1'b0);
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd9; alu_wb_data = 32'h0000_0009;
    tick();
    alu_wb_valid = 1'b0;
    chk("spur_set", err_spurious, 1'b1);
    tick(); tick();
    chk("spur_sticky", err_spurious, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("spur_rst", err_spurious, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Controller for the register bank's single write port.
- Arbitrates writeback requests from two requesters, the ALU and the load unit, onto that port using a valid/ready handshake. Load has priority, with a starvation guard for the ALU.
- Keeps a per-register busy scoreboard so decode stalls on RAW/WAW hazards.
- Sits between execute/memory stages and the register bank; decode consumes its stall output.

Parameters:
- XLEN, 32, data width of writeback and register file.
- STARVE_LIMIT, 4, consecutive lost cycles after which a waiting ALU request gets priority (range 1..15).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- dec_valid  in  1  decode presenting an instruction
- dec_rs1  in  5  source register 1 index
- dec_rs2  in  5  source register 2 index
- dec_rd  in  5  destination index
- dec_wr_en  in  1  instruction writes rd
- dec_stall  out  1  hazard stall to decode (combinational)
- alu_wb_valid  in  1  ALU writeback request
- alu_wb_rd  in  5  ALU destination
- alu_wb_data  in  XLEN  ALU result
- alu_wb_ready  out  1  ALU request granted this cycle
- ld_wb_valid  in  1  load writeback request
- ld_wb_rd  in  5  load destination
- ld_wb_data  in  XLEN  load data
- ld_wb_ready  out  1  load request granted this cycle
- rf_we  out  1  register bank write enable (registered)
- rf_waddr  out  5  register bank write address (registered)
- rf_wdata  out  XLEN  register bank write data (registered)
- busy_vec  out  32  scoreboard, bit i = write to xi outstanding

Behaviour:
- Reset (rst=1 at posedge):
  - rf_we=0, rf_waddr=0, rf_wdata=0, busy_vec=0.
  - Priority state=PRIO_LD, starve_cnt=0.
  - ready outputs are 0 while rst is high.
- Handshake:
  - A transfer occurs when valid&ready.
  - A requester holds valid, rd and data stable until ready.
  - At most one ready is high per cycle; ready is combinational from valids and state.
- Arbitration FSM:
  - PRIO_LD: ld_wb_ready=ld_wb_valid; alu_wb_ready=alu_wb_valid&!ld_wb_valid.
  - PRIO_ALU: alu_wb_ready=alu_wb_valid; ld_wb_ready=ld_wb_valid&!alu_wb_valid.
- starve_cnt:
  - Increments when alu_wb_valid&ld_wb_valid&ld granted.
  - Clears when the ALU is granted or alu_wb_valid=0.
  - When it reaches STARVE_LIMIT, the next state is PRIO_ALU.
  - PRIO_ALU returns to PRIO_LD on the cycle after an ALU grant, or if alu_wb_valid drops; starve_cnt clears.
- Write port:
  - 1-cycle latency: the cycle after a grant, rf_we=1 and rf_waddr/rf_wdata hold the granted rd/data.
  - Grant with rd=0: the handshake completes, rf_we stays 0 (x0 hardwired).
  - No grant: rf_we=0; waddr/wdata hold their previous values.
- Scoreboard:
  - dec_stall = dec_valid & (busy[rs1] | busy[rs2] | (dec_wr_en & busy[rd])).
  - Issue = dec_valid&!dec_stall&dec_wr_en&dec_rd!=0 sets busy[dec_rd] at the next edge.
  - A grant clears busy[granted rd] at the next edge.
  - Issue of rd and grant clearing rd in the same cycle cannot coexist: busy[rd]=1 forces a stall. Stall uses registered busy, so there is no same-cycle clear-through.
  - busy[0] is always 0.
  - Writeback to a non-busy register is still written; busy is unchanged.
- rst mid-operation: all pending busy bits are cleared; any grant in that cycle is discarded (rf_we=0 next cycle).

Optional Feature:
- Macro WB_SPURIOUS_CHECK_EN.
- Defined: adds output err_spurious (1 bit, sticky, registered), set when a grant has rd!=0 and busy[rd]=0; cleared only by rst.
- Undefined: the port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - XLEN and REG_ADDR_W=5 constants.
  - prio_state_t enum {PRIO_LD, PRIO_ALU}.
  - Writeback request struct (valid, rd, data).
- One sub-module, wb_scoreboard: busy_vec register with set/clear ports plus the stall compare.
- Arbiter FSM and write-port registers stay in the top.

Test Plan:
- Reset: drive all valids high with rst=1 for 2 cycles -> both readies 0, rf_we=0, busy_vec=0; after rst=0, ld_wb_ready=1 the first cycle.
- Single ALU write: issue rd=5 -> busy_vec[5]=1 next cycle; alu_wb_valid, rd=5, data=32'hDEADBEEF -> ready same cycle; next cycle rf_we=1, waddr=5, wdata=DEADBEEF, busy_vec[5]=0.
- Hazard stall: busy[7]=1, decode rs1=7 -> dec_stall=1; decode rs1=3, rs2=4, rd=7, wr_en=1 -> dec_stall=1; rd=8 -> dec_stall=0.
- Starvation (STARVE_LIMIT=4): both valid continuously -> load granted 4 cycles, ALU granted on the 5th, load on the 6th.
- x0 write: ld_wb_rd=0 granted -> rf_we stays 0 next cycle, busy_vec unchanged; issue with rd=0 -> no busy bit set.
- With WB_SPURIOUS_CHECK_EN: ALU writeback to rd=9 while busy[9]=0 -> err_spurious=1 next cycle and stays 1 until rst.
